// File: rtl/blank_window_arbiter.sv
// Blanking-window write-port arbiter.
// Shares one display-resource write port between N_REQ requesters. The port
// is granted only while the timing generator reports blanking. Requesters are
// served round-robin, each grant is capped at MAX_BURST beats, and a dead
// cycle follows every release. The block also keeps per-frame missed-request
// flags and a per-frame beat count.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant; arbitrate when the window is open and a request is up
//   GRANT | one requester owns the port; count beats, watch release causes
//   GAP   | one dead turnaround cycle after a release
module blank_window_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int MAX_BURST = 16,
  parameter  int HBLNK_EN  = 0,
  localparam int IDX_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vblnk,
  input  logic             hblnk,
  input  logic             new_frame,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic [N_REQ-1:0] missed,
  output logic [15:0]      frame_beats
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic             window_q;
  logic [N_REQ-1:0] missed_q, missed_d;
  logic [15:0]      acc_q, acc_d, acc_sum;
  logic [15:0]      frame_beats_q, frame_beats_d;

  logic             window;
  logic             beat;
  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] next_ptr;

  // The grant is masked by the live window so it closes with zero latency.
  assign window = vblnk | ((HBLNK_EN != 0) & hblnk);
  assign gnt    = gnt_q & {N_REQ{window}};
  assign beat   = |(gnt & req);

  assign next_ptr = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

  // Round-robin pick: walk from rr_ptr downward in priority so the candidate
  // closest to rr_ptr (with wrap) is written last and wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N_REQ)) cand = cand - (IDX_W + 1)'(N_REQ);
      if (req[cand[IDX_W-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state logic for the grant FSM.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (window && sel_vld) begin
          gnt_d      = N_REQ'(1) << sel_idx;
          idx_d      = sel_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (beat) beat_cnt_d = beat_cnt_q + 8'd1;
        // A window close also advances rr_ptr so the next window starts fair.
        if (!req[idx_q] || !window ||
            (beat && beat_cnt_q == 8'(MAX_BURST - 1))) begin
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
          state_d  = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Missed flags and saturating per-frame beat accumulation.
  always_comb begin
    acc_sum = (beat && acc_q != 16'hFFFF) ? acc_q + 16'd1 : acc_q;
    if (new_frame) begin
      acc_d         = '0;
      frame_beats_d = acc_sum;
      missed_d      = '0;
    end else begin
      acc_d         = acc_sum;
      frame_beats_d = frame_beats_q;
      missed_d      = missed_q;
    end
    // Setting on window fall wins over the new_frame clear in the same cycle.
    if (window_q && !window) missed_d = missed_d | req;
  end

  // FSM and arbitration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Window history, missed flags and beat statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q      <= 1'b0;
      missed_q      <= '0;
      acc_q         <= '0;
      frame_beats_q <= '0;
    end else begin
      window_q      <= window;
      missed_q      <= missed_d;
      acc_q         <= acc_d;
      frame_beats_q <= frame_beats_d;
    end
  end

  assign gnt_idx     = idx_q;
  assign busy        = (state_q != IDLE);
  assign missed      = missed_q;
  assign frame_beats = frame_beats_q;

endmodule
